// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection simulator command driver.
package intersection_pkg;

    localparam logic [2:0] MODE_REM_A = 3'b000;
    localparam logic [2:0] MODE_REM_B = 3'b001;
    localparam logic [2:0] MODE_ADD_A = 3'b010;
    localparam logic [2:0] MODE_ADD_B = 3'b011;
    localparam logic [2:0] MODE_DISP  = 3'b100;

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] plate;
    } cmd_t;

    // Remove commands carry no plate; store zero so the simulator sees a clean bus.
    function automatic cmd_t make_cmd(logic [1:0] op, logic [4:0] plate);
        cmd_t c;
        c.op    = op;
        c.plate = (op == MODE_ADD_A[1:0] || op == MODE_ADD_B[1:0]) ? plate : 5'd0;
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO with occupancy count and async active-low reset.
module cmd_fifo
    import intersection_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  cmd_t                     data_i,
    input  logic                     pop_i,
    output cmd_t                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntFW = PtrW + 1;

    cmd_t              mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntFW-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CntFW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/intersection_cmd_driver.sv
// Buffers add/remove commands and replays each as a setup + clean action pulse.
// Define IDLE_DISPLAY_EN to park mode/plateIn on display mode while idle.
module intersection_cmd_driver
    import intersection_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned PULSE_CYC  = 1,
    parameter int unsigned GAP_CYC    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [2:0]                    cmd_mode_i,
    input  logic [4:0]                    cmd_plate_i,
    output logic [2:0]                    mode_o,
    output logic [4:0]                    plate_in_o,
    output logic                          action_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o,
    output logic                          drop_pulse_o
);

`ifdef IDLE_DISPLAY_EN
    localparam logic [2:0] IdleMode = MODE_DISP;
`else
    localparam logic [2:0] IdleMode = MODE_REM_A;
`endif

    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] GapLd   = CntW'(GAP_CYC - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        mode_q, mode_d;
    logic [4:0]        plate_q, plate_d;
    logic              action_q, action_d;
    logic              drop_q, drop_d;

    logic              fifo_full, fifo_empty;
    cmd_t              fifo_rd;
    logic              accept, push, pop, start;

    // Ready is taken from the pre-edge count, so a full FIFO refuses even while popping.
    assign cmd_ready_o = !fifo_full;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign push        = accept && !cmd_mode_i[2];
    assign drop_d      = accept && cmd_mode_i[2];

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (make_cmd(cmd_mode_i[1:0], cmd_plate_i)),
        .pop_i   (pop),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending_o)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        plate_d  = plate_q;
        action_d = action_q;
        start    = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) start = 1'b1;
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    action_d = 1'b1;
                    state_d  = StPulse;
                    cnt_d    = PulseLd;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    action_d = 1'b0;
                    state_d  = StGap;
                    cnt_d    = GapLd;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
`ifdef IDLE_DISPLAY_EN
                    mode_d  = MODE_DISP;
                    plate_d = 5'd0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            pop      = 1'b1;
            state_d  = StSetup;
            cnt_d    = SetupLd;
            mode_d   = {1'b0, fifo_rd.op};
            plate_d  = fifo_rd.plate;
            action_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mode_q   <= IdleMode;
            plate_q  <= 5'd0;
            action_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            plate_q  <= plate_d;
            action_q <= action_d;
            drop_q   <= drop_d;
        end
    end

    assign mode_o       = mode_q;
    assign plate_in_o   = plate_q;
    assign action_o     = action_q;
    assign busy_o       = (state_q != StIdle);
    assign drop_pulse_o = drop_q;

endmodule

// File: tb/tb_intersection_cmd_driver.sv
// Self-checking bench: directed table, hand sequences and a timing-based reference model.
module tb_intersection_cmd_driver;

    localparam int unsigned D = 4;
    localparam int unsigned S = 1;
    localparam int unsigned P = 1;
    localparam int unsigned G = 1;
    localparam int          L = S + P + G;

`ifdef IDLE_DISPLAY_EN
    localparam logic [2:0] IDLE_M = 3'd4;
    localparam bit         DISP   = 1'b1;
`else
    localparam logic [2:0] IDLE_M = 3'd0;
    localparam bit         DISP   = 1'b0;
`endif

    typedef logic [14:0] ovec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_mode = 3'd0;
    logic [4:0] cmd_plate = 5'd0;
    logic       cmd_ready, action, busy, drop_pulse;
    logic [2:0] mode;
    logic [4:0] plate_in;
    logic [2:0] pending;
    ovec_t      act_vec;

    always #5 clk = ~clk;

    intersection_cmd_driver #(
        .FIFO_DEPTH (D),
        .SETUP_CYC  (S),
        .PULSE_CYC  (P),
        .GAP_CYC    (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_mode_i   (cmd_mode),
        .cmd_plate_i  (cmd_plate),
        .mode_o       (mode),
        .plate_in_o   (plate_in),
        .action_o     (action),
        .busy_o       (busy),
        .pending_o    (pending),
        .drop_pulse_o (drop_pulse)
    );

    assign act_vec = {cmd_ready, mode, plate_in, action, busy, pending, drop_pulse};

    int nvec = 0;
    int nerr = 0;

    function automatic ovec_t ov(bit r, logic [2:0] m, logic [4:0] p, bit a, bit b,
                                 logic [2:0] n, bit d);
        return {r, m, p, a, b, n, d};
    endfunction

    task automatic check(input string name, input ovec_t got, input ovec_t exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got rdy/mode/plate/act/busy/pend/drop=%b required %b",
                     name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Reference model: each popped command owns a window of L edges starting at its pop edge.
    int         mq[$];
    int         me, mstart;
    bit         mact, mdrop;
    logic [2:0] mmode;
    logic [4:0] mplate;

    task automatic model_reset();
        mq.delete();
        me = 0; mstart = 0; mact = 0; mdrop = 0;
        mmode = IDLE_M; mplate = 5'd0;
    endtask

    task automatic model_step();
        bit rdy;
        int c;
        me++;
        rdy = (mq.size() < D);
        if (mact && me == mstart + L) begin
            mact = 0;
            if (DISP) begin mmode = 3'd4; mplate = 5'd0; end
        end
        if (!mact && mq.size() > 0) begin
            c = mq.pop_front();
            mact = 1; mstart = me;
            mmode = {1'b0, c[6:5]};
            mplate = c[4:0];
        end
        if (cmd_valid && rdy && !cmd_mode[2])
            mq.push_back(int'({cmd_mode[1:0], (cmd_mode[1] ? cmd_plate : 5'd0)}));
        mdrop = cmd_valid && rdy && cmd_mode[2];
    endtask

    function automatic ovec_t model_vec();
        bit a;
        a = mact && (me >= mstart + S) && (me < mstart + S + P);
        return {(mq.size() < D), mmode, mplate, a, mact, 3'(mq.size()), mdrop};
    endfunction

    // Monitors updated every cycle.
    logic       prev_act = 1'b0;
    logic [4:0] prev_plate = 5'd0;
    int         rises = 0;
    int         rise_edge[$];
    logic [4:0] rise_plate[$];
    int         plate_viol = 0;
    bit         saw_full = 0;

    task automatic clear_mon();
        rises = 0; rise_edge.delete(); rise_plate.delete(); plate_viol = 0; saw_full = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (action && !prev_act) begin
            rises++;
            rise_edge.push_back(me);
            rise_plate.push_back(plate_in);
        end
        if (plate_in !== prev_plate && (action || prev_act)) plate_viol++;
        if (pending == 3'd4 && !cmd_ready) saw_full = 1;
        prev_act = action;
        prev_plate = plate_in;
        check("model", act_vec, model_vec());
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", act_vec, ov(1, IDLE_M, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        model_reset();
        prev_act = 1'b0;
        prev_plate = 5'd0;
    endtask

    typedef struct {
        bit         v;
        logic [2:0] m;
        logic [4:0] p;
        ovec_t      exp;
    } vec_t;

    vec_t       tbl[10];
    logic [4:0] full_plates[6];
    logic [2:0] hm, hm2;
    logic [4:0] hp;
    int         idx, guard;
    bit         acc;

    initial begin
        hm  = DISP ? 3'd4 : 3'd3;
        hp  = DISP ? 5'd0 : 5'd29;
        hm2 = DISP ? 3'd4 : 3'd1;
        tbl[0] = '{1, 3'b011, 5'd29, ov(1, IDLE_M, 0, 0, 0, 1, 0)};
        tbl[1] = '{0, 3'b000, 5'd0,  ov(1, 3, 29, 0, 1, 0, 0)};
        tbl[2] = '{0, 3'b000, 5'd0,  ov(1, 3, 29, 1, 1, 0, 0)};
        tbl[3] = '{0, 3'b000, 5'd0,  ov(1, 3, 29, 0, 1, 0, 0)};
        tbl[4] = '{1, 3'b001, 5'd31, ov(1, hm, hp, 0, 0, 1, 0)};
        tbl[5] = '{1, 3'b110, 5'd5,  ov(1, 1, 0, 0, 1, 0, 1)};
        tbl[6] = '{0, 3'b000, 5'd0,  ov(1, 1, 0, 1, 1, 0, 0)};
        tbl[7] = '{0, 3'b000, 5'd0,  ov(1, 1, 0, 0, 1, 0, 0)};
        tbl[8] = '{0, 3'b000, 5'd0,  ov(1, hm2, 0, 0, 0, 0, 0)};
        tbl[9] = '{0, 3'b000, 5'd0,  ov(1, hm2, 0, 0, 0, 0, 0)};
        full_plates = '{5'd3, 5'd7, 5'd11, 5'd19, 5'd23, 5'd27};

        // Reset, then a quiet idle stretch.
        do_reset();
        clear_mon();
        repeat (20) tick();
        check_int("idle_no_pulse", rises, 0);

        // Directed table: single addB 29, then remB 31 followed by a dropped display command.
        for (int i = 0; i < 10; i++) begin
            cmd_valid = tbl[i].v;
            cmd_mode  = tbl[i].m;
            cmd_plate = tbl[i].p;
            tick();
            check($sformatf("tbl%0d", i), act_vec, tbl[i].exp);
        end
        cmd_valid = 1'b0;

        // Back-to-back commands.
        clear_mon();
        cmd_valid = 1'b1; cmd_mode = 3'b011; cmd_plate = 5'd29;
        tick();
        cmd_plate = 5'd17;
        tick();
        cmd_valid = 1'b0;
        repeat (12) tick();
        check_int("b2b_pulses", rises, 2);
        check_int("b2b_spacing", (rises == 2) ? rise_edge[1] - rise_edge[0] : -1, L);
        check_int("b2b_plate0", (rises >= 1) ? int'(rise_plate[0]) : -1, 29);
        check_int("b2b_plate1", (rises == 2) ? int'(rise_plate[1]) : -1, 17);
        check_int("b2b_plate_stable", plate_viol, 0);

        // Fill the FIFO with held-valid adds.
        clear_mon();
        idx = 0; guard = 0;
        while (idx < 6 && guard < 200) begin
            cmd_valid = 1'b1;
            cmd_mode  = idx[0] ? 3'b011 : 3'b010;
            cmd_plate = full_plates[idx];
            acc = cmd_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        cmd_valid = 1'b0;
        repeat (30) tick();
        check_int("full_accepted", idx, 6);
        check_int("full_ready_low", int'(saw_full), 1);
        check_int("full_pulses", rises, 6);
        for (int i = 0; i < 6; i++)
            check_int($sformatf("full_order%0d", i),
                      (i < rises) ? int'(rise_plate[i]) : -1, int'(full_plates[i]));

        // Reset asserted while action is high.
        clear_mon();
        cmd_valid = 1'b1; cmd_mode = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cmd_plate = 5'(i + 4);
            tick();
        end
        cmd_valid = 1'b0;
        guard = 0;
        while (action !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        check_int("rst_pulse_seen", int'(action === 1'b1), 1);
        #2 rst_n = 1'b0;
        #1;
        check_int("rst_async_action", int'(action), 0);
        check_int("rst_async_pending", int'(pending), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_act = 1'b0;
        prev_plate = 5'd0;
        clear_mon();
        repeat (10) tick();
        check_int("rst_no_pulse", rises, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cmd_valid = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cmd_mode  = 3'($urandom_range(0, 7));
            cmd_plate = 5'($urandom_range(0, 31));
            tick();
        end
        cmd_valid = 1'b0;
        repeat (20) tick();
        check_int("drain_pending", int'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
